// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM for the multicycle RV32I core.
// The state register is updated in one always_ff block.
// A single always_comb block computes the next state and all datapath controls.
// Outputs depend on the current state only, except for two terms:
// FETCH raises pc_write and ir_write in the cycle in which memory reports ready.
module multicycle_control_unit #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_source_o,
  output logic       ir_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_co_o,
  output logic       is_immediate_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    AUIPC    = 4'd12,
    LUI      = 4'd13,
    ILLEGAL  = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state_q;
  state_t state_d;

  // State register: reset forces FETCH, even in the middle of an instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  // Every control is first defaulted to zero.
  // During reset, the whole control word is forced to zero, so no strobe can escape.
  always_comb begin
    state_d         = state_q;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 1'b0;
    ir_write_o      = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_co_o        = 2'b00;
    is_immediate_o  = 1'b0;

    case (state_q)
      FETCH: begin
        // PC + 4 is computed while the instruction is read.
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
        if (mem_ready_i) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Old PC plus the immediate gives the branch/JAL target, which lands in ALUOut.
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_AUIPC:          state_d = AUIPC;
          OP_LUI:            state_d = LUI;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = MEMWB;
        end
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          state_d = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a_o = 2'b01;
        alu_co_o    = 2'b10;
        state_d     = ALUWB;
      end
      EXEC_I: begin
        alu_src_a_o    = 2'b01;
        alu_src_b_o    = 2'b10;
        alu_co_o       = 2'b10;
        is_immediate_o = 1'b1;
        state_d        = ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        // The compare runs on rs1/rs2.
        // The datapath gates the PC load with the result; the target comes from ALUOut.
        alu_src_a_o     = 2'b01;
        alu_co_o        = 2'b01;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 1'b1;
        state_d         = FETCH;
      end
      JAL: begin
        // The PC still holds old+4, which becomes the link value written to rd.
        pc_write_o   = 1'b1;
        pc_source_o  = 1'b1;
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b10;
        state_d      = FETCH;
      end
      JALR: begin
        // The target is taken live from the ALU.
        // The rd write sees the PC before this edge updates it.
        alu_src_a_o  = 2'b01;
        alu_src_b_o  = 2'b10;
        pc_write_o   = 1'b1;
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b10;
        state_d      = FETCH;
      end
      AUIPC: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        state_d     = ALUWB;
      end
      LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b10;
        state_d     = ALUWB;
      end
      ILLEGAL: begin
        state_d = ILLEGAL;
      end
      default: begin
        state_d = state_t'(RESET_STATE);
      end
    endcase

    if (rst) begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_source_o     = 1'b0;
      ir_write_o      = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      reg_write_o     = 1'b0;
      mem_to_reg_o    = 2'b00;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      alu_co_o        = 2'b00;
      is_immediate_o  = 1'b0;
    end
  end

  assign illegal_o = (state_q == ILLEGAL);
  assign state_o   = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback.
- Drives the datapath muxes, register-file/PC/IR write strobes and memory strobes.
- Supplies the 2-bit ALU class code (00 load/store add, 01 branch, 10 ALU) and the is-immediate flag consumed by the ALU control decoder.
- Stalls on a unified memory ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); not intended to change

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode_i  input  7  IR[6:0]; IR is stable from DECODE until next FETCH
mem_ready_i  input  1  memory completes the current read/write this cycle
pc_write_o  output  1  unconditional PC load
pc_write_cond_o  output  1  PC load if ALU branch condition true (gated in datapath)
pc_source_o  output  1  0: live ALU result, 1: ALUOut register
ir_write_o  output  1  load IR and old-PC register
iord_o  output  1  memory address: 0 PC, 1 ALUOut
mem_read_o  output  1  memory read strobe
mem_write_o  output  1  memory write strobe
reg_write_o  output  1  register file write
mem_to_reg_o  output  2  rd data: 00 ALUOut, 01 MDR, 10 PC
alu_src_a_o  output  2  00 PC, 01 rs1, 10 old PC, 11 zero
alu_src_b_o  output  2  00 rs2, 01 const 4, 10 immediate
alu_co_o  output  2  ALU class to ALU control: 00 add, 01 branch, 10 func
is_immediate_o  output  1  forwarded to ALU control
illegal_o  output  1  sticky illegal-opcode flag
state_o  output  4  current state, debug

Behaviour:
- Outputs not listed for a state are 0. While rst=1, all strobes read 0. State register is set to FETCH on the first clock with rst=1, including mid-instruction. No strobe is issued in the reset cycle.
- State encoding (state_o):
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
  - 6 EXEC_R, 7 EXEC_I, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR
  - 12 AUIPC, 13 LUI, 14 ILLEGAL
- FETCH: mem_read=1, iord=0, src_a=00, src_b=01, alu_co=00. pc_write and ir_write are asserted only when mem_ready_i=1 (the only Mealy terms). Go to DECODE on mem_ready_i=1, otherwise hold.
- DECODE: src_a=10, src_b=10, alu_co=00 (branch/JAL target into ALUOut). Next state by opcode_i:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0010111 -> AUIPC
  - 0110111 -> LUI
  - other -> ILLEGAL
- MEMADR: src_a=01, src_b=10, alu_co=00. Go to MEMREAD if opcode_i=0000011, else MEMWRITE.
- MEMREAD: mem_read=1, iord=1. Hold until mem_ready_i, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=01 -> FETCH.
- MEMWRITE: mem_write=1, iord=1. Hold until mem_ready_i, then FETCH.
- EXEC_R: src_a=01, src_b=00, alu_co=10, is_immediate=0 -> ALUWB.
- EXEC_I: src_a=01, src_b=10, alu_co=10, is_immediate=1 -> ALUWB.
- ALUWB: reg_write=1, mem_to_reg=00 -> FETCH.
- BRANCH: src_a=01, src_b=00, alu_co=01, pc_write_cond=1, pc_source=1 -> FETCH.
- JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10 (PC already old+4) -> FETCH.
- JALR: src_a=01, src_b=10, alu_co=00, pc_write=1, pc_source=0, reg_write=1, mem_to_reg=10 -> FETCH. The rd write sees the pre-update PC.
- AUIPC: src_a=10, src_b=10, alu_co=00 -> ALUWB.
- LUI: src_a=11, src_b=10, alu_co=00 -> ALUWB.
- ILLEGAL: all strobes 0, illegal_o=1, absorbing until rst. illegal_o is 0 in every other state.
- Memory strobes stay asserted for every wait cycle; no timeout.
- Instruction latency in cycles, zero wait states:
  - R/I-ALU, AUIPC, LUI: 4
  - load: 5
  - store: 4
  - branch, JAL, JALR: 3
- Each memory wait cycle adds 1.

Test Plan:
- rst held 2 cycles, then add (0110011), mem_ready_i=1 -> state_o 0,1,6,8,0; in EXEC_R alu_co=10, is_immediate=0; in ALUWB reg_write=1, mem_to_reg=00; no strobes during rst.
- addi (0010011), fetch with 2 wait cycles -> FETCH held 3 cycles with mem_read=1; pc_write/ir_write high only in the third; EXEC_I drives is_immediate=1, src_b=10.
- lw (0000011), MEMREAD ready after 1 wait -> states 0,1,2,3,3,4,0; iord=1 in both MEMREAD cycles; MEMWB mem_to_reg=01. sw (0100011) -> 0,1,2,5,0 with mem_write=1.
- beq (1100011) -> BRANCH drives alu_co=01, pc_write_cond=1, pc_source=1, pc_write=0. jal -> pc_write=1, reg_write=1, mem_to_reg=10 in one cycle.
- Opcode 1111111 at DECODE -> state 14, illegal_o=1 for 10+ cycles, all strobes 0; rst clears it to FETCH.
- rst asserted in MEMWRITE while mem_ready_i=0 -> next state FETCH, mem_write drops in the reset cycle.
